param_watch: RTL
================

# param_watch

Parametrised successor to the four-digit minute/hour watch: one block keeps HH:MM:SS in BCD, derives its one-second tick from the system clock, and supports 12-hour or 24-hour counting. A start/stop/set state machine lets the user edit the time. An optional alarm can be compiled in. It sits between the button debouncers and the seven-segment display driver.

## Interface
Parameters:
- CLK_PER_SEC, default 100: clk cycles per second, must be ≥ 2.
- MODE_24H, default 1: 1 selects the 00–23 hour range; 0 selects 12-hour mode, range 01–12 with a pm flag.

Ports:
- clk  in  1  system clock; every flop is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start_resume  in  1  single-cycle pulse: start or resume counting.
- stop  in  1  single-cycle pulse: halt counting.
- setTime  in  1  level; high holds the block in edit mode.
- set_field  in  2  edit target: 0 = minutes, 1 = hours, 2 = clear seconds, 3 = reserved (no effect).
- inc  in  1  single-cycle pulse: increment the selected field.
- hr1, hr0, min1, min0, sec1, sec0  out  4 each  BCD time digits.
- pm  out  1  12-hour PM flag; constant 0 when MODE_24H = 1.
- running  out  1  high in RUN.
- sec_tick  out  1  one-cycle pulse on each counted second.

## Operation
- FSM states: STOP, RUN, SET. Reset enters STOP.
- setTime = 1 → SET from any state; this has the highest priority.
- In SET, setTime = 0 → STOP. Counting never resumes automatically.
- STOP + start_resume → RUN.
- RUN + stop → STOP. If stop and start_resume arrive in the same cycle, stop wins and the state is STOP.
- Prescaler counts 0..CLK_PER_SEC-1, and only in RUN:
  - held, not cleared, in STOP, so resume continues the partial second;
  - cleared on entry to SET.
- At prescaler terminal count, seconds increment. Carry chain:
  - seconds 59 → 00 carries into minutes;
  - minutes 59 → 00 carries into hours;
  - 24-hour mode: hours 23 → 00;
  - 12-hour mode: hours 11 → 12 toggles pm, and 12 → 01.
- SET editing:
  - an inc pulse increments the selected field modulo its range, with no carry into the next field;
  - in 12-hour mode, an hour edit from 11 → 12 toggles pm;
  - set_field = 2 with inc clears seconds to 00;
  - inc outside SET is ignored.
- Reset values:
  - 24-hour mode: time 00:00:00, pm = 0;
  - 12-hour mode: time 12:00:00, pm = 0;
  - running = 0, sec_tick = 0, prescaler = 0, state STOP.
- Every digit is always valid BCD, 0–9; no illegal value is ever produced.

## Timing
- All outputs are registered.
- Time digits and sec_tick update on the same edge where the prescaler wraps. The first tick arrives CLK_PER_SEC cycles after entering RUN from a cleared prescaler.
- FSM transitions and running take effect on the edge after the input pulse, so latency is 1 cycle.
- inc edits are visible 1 cycle after the pulse.
- A full hour/day carry ripples within that same single edge; there is no multi-cycle ripple.
- Reset asserted mid-second or mid-edit returns every register to its reset value on the next edge.

## Configuration
- WATCH_ALARM_EN defined: adds the alarm.
  - Added ports: alarm_on (in, 1), alarm_edit (in, 1), alarm (out, 1).
  - In SET with alarm_edit = 1, inc edits the alarm hour/minute registers instead of the time. The alarm resets to 00:00, or to 12:00 AM in 12-hour mode.
  - alarm rises on the tick that produces HH:MM:00 equal to the alarm time while alarm_on = 1.
  - alarm clears on stop, alarm_on = 0, reset, or the next minute carry.
- WATCH_ALARM_EN undefined: the alarm ports, registers and compare logic are absent. The remaining behaviour is identical.

## Structure
- Package watch_pkg holds:
  - state enum (STOP/RUN/SET);
  - set_field constants;
  - 4-bit BCD digit typedef;
  - limit constants 59, 23, 12.
- Sub-module bcd_mod_counter:
  - two-digit BCD counter with parameter MAX;
  - inputs en and clr;
  - outputs carry and wrap;
  - instantiated for seconds and minutes.
- Hours and pm logic live in param_watch itself, because of the mode-dependent wrap.

## Test plan
- Run with CLK_PER_SEC = 4: reset → 00:00:00, running = 0. Pulse start_resume; after 4 cycles sec_tick = 1 and time = 00:00:01.
- Load 23:59:59 via SET, MODE_24H = 1, then RUN → one tick later 00:00:00. With MODE_24H = 0 from 11:59:59 AM → 12:00:00, pm = 1.
- In RUN, pulse stop after 2 prescaler counts → digits frozen. Resume → next tick after 2 cycles, not 4.
- Same-cycle stop and start_resume in RUN → STOP. Raise setTime during RUN → running = 0 next cycle. Apply inc to minutes at 59 → 00 with hours unchanged.
- Assert reset mid-edit at 07:42:13 → 00:00:00 next edge.
- WATCH_ALARM_EN: set alarm 00:01, alarm_on = 1, run from 00:00:58 → alarm = 1 at 00:01:00; stop → alarm = 0.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared types and helpers for the BCD watch: FSM states, edit field codes,
// digit limits and the two-digit BCD increment used by every time field.
package watch_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        SET  = 2'd2
    } state_t;

    localparam logic [1:0] FIELD_MIN     = 2'd0;
    localparam logic [1:0] FIELD_HR      = 2'd1;
    localparam logic [1:0] FIELD_SEC_CLR = 2'd2;
    localparam logic [1:0] FIELD_RSVD    = 2'd3;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t d1;
        bcd_t d0;
    } bcd2_t;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HR24_MAX = 23;
    localparam int HR12_MAX = 12;

    function automatic bcd2_t bcd2_of(input int v);
        bcd2_t r;
        r.d1 = bcd_t'(v / 10);
        r.d0 = bcd_t'(v % 10);
        return r;
    endfunction

    // Wraps to 00 after max; callers never hold a value above max.
    function automatic bcd2_t bcd2_inc(input bcd2_t v, input int max);
        bcd2_t r;
        if (v == bcd2_of(max)) begin
            r = '0;
        end else if (v.d0 == 4'd9) begin
            r.d1 = v.d1 + 4'd1;
            r.d0 = 4'd0;
        end else begin
            r.d1 = v.d1;
            r.d0 = v.d0 + 4'd1;
        end
        return r;
    endfunction

    function automatic bcd2_t hr_next(input bcd2_t h, input logic mode24);
        bcd2_t r;
        if (mode24)
            r = bcd2_inc(h, HR24_MAX);
        else if (h == bcd2_of(HR12_MAX))
            r = bcd2_of(1);
        else
            r = bcd2_inc(h, HR12_MAX);
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping 00..MAX; wrap flags the terminal value, carry = en at terminal.
// Latency: value updates on the edge after en/clr; carry/wrap are combinational from state.
// Backpressure: none; en and clr are accepted every cycle, clr has priority.
module bcd_mod_counter
    import watch_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       carry,
    output logic       wrap
);

    bcd2_t val;

    assign wrap  = (val == bcd2_of(MAX));
    assign carry = en & wrap;
    assign d1    = val.d1;
    assign d0    = val.d0;

    always_ff @(posedge clk) begin
        if (reset || clr)
            val <= '0;
        else if (en)
            val <= bcd2_inc(val, MAX);
    end

endmodule

// File: rtl/param_watch.sv
// HH:MM:SS BCD watch with STOP/RUN/SET control, 12/24-hour mode; WATCH_ALARM_EN adds an alarm.
// Latency: state, running and inc edits take effect 1 cycle after the pulse; digits move on prescaler wrap.
// Backpressure: none; control pulses are consumed the cycle they arrive.
module param_watch
    import watch_pkg::*;
#(
    parameter int CLK_PER_SEC = 100,
    parameter int MODE_24H    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_resume,
    input  logic       stop,
    input  logic       setTime,
    input  logic [1:0] set_field,
    input  logic       inc,
    output logic [3:0] hr1,
    output logic [3:0] hr0,
    output logic [3:0] min1,
    output logic [3:0] min0,
    output logic [3:0] sec1,
    output logic [3:0] sec0,
    output logic       pm,
    output logic       running,
    output logic       sec_tick
`ifdef WATCH_ALARM_EN
    ,
    input  logic       alarm_on,
    input  logic       alarm_edit,
    output logic       alarm
`endif
);

    localparam int          PW     = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(CLK_PER_SEC - 1);
    localparam logic        MODE24 = (MODE_24H != 0);
    localparam bcd2_t       HR_RST = MODE24 ? bcd2_of(0) : bcd2_of(HR12_MAX);

    state_t        state, state_nxt;
    logic [PW-1:0] presc;
    bcd2_t         hr;
    logic          tick, edit, time_edit;
    logic          sec_carry, sec_wrap, min_carry, min_wrap;
    logic          hr_inc, pm_tgl;
    bcd2_t         hr_nx;
    logic          unused_cnt;

    always_comb begin
        state_nxt = state;
        if (setTime) begin
            state_nxt = SET;
        end else begin
            case (state)
                STOP:    if (start_resume) state_nxt = RUN;
                RUN:     if (stop)         state_nxt = STOP;
                SET:     state_nxt = STOP;
                default: state_nxt = STOP;
            endcase
        end
    end

    assign tick = (state == RUN) && (presc == P_LAST);
    assign edit = (state == SET) && inc;
`ifdef WATCH_ALARM_EN
    assign time_edit = edit && !alarm_edit;
`else
    assign time_edit = edit;
`endif

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk   (clk),
        .reset (reset),
        .en    (tick),
        .clr   (time_edit && (set_field == FIELD_SEC_CLR)),
        .d1    (sec1),
        .d0    (sec0),
        .carry (sec_carry),
        .wrap  (sec_wrap)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk   (clk),
        .reset (reset),
        .en    (sec_carry || (time_edit && (set_field == FIELD_MIN))),
        .clr   (1'b0),
        .d1    (min1),
        .d0    (min0),
        .carry (min_carry),
        .wrap  (min_wrap)
    );

    assign unused_cnt = &{1'b0, sec_wrap, min_carry};

    // Run carries need the seconds carry as well, so a minutes edit at 59 never bumps hours.
    assign hr_inc = (sec_carry && min_wrap) || (time_edit && (set_field == FIELD_HR));
    assign hr_nx  = hr_next(hr, MODE24);
    assign pm_tgl = !MODE24 && (hr == bcd2_of(11));
    assign hr1    = hr.d1;
    assign hr0    = hr.d0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= STOP;
            running  <= 1'b0;
            sec_tick <= 1'b0;
            presc    <= '0;
            hr       <= HR_RST;
            pm       <= 1'b0;
        end else begin
            state    <= state_nxt;
            running  <= (state_nxt == RUN);
            sec_tick <= tick;
            if (state_nxt == SET)
                presc <= '0;
            else if (state == RUN)
                presc <= tick ? '0 : presc + 1'b1;
            if (hr_inc) begin
                hr <= hr_nx;
                if (pm_tgl)
                    pm <= ~pm;
            end
        end
    end

`ifdef WATCH_ALARM_EN
    bcd2_t al_min, al_hr;
    logic  al_pm, al_edit, al_hit;
    bcd2_t nxt_min, nxt_hr;
    logic  nxt_pm;

    assign al_edit = edit && alarm_edit;
    // Time the current tick produces; only meaningful when sec_carry is high.
    assign nxt_min = bcd2_inc({min1, min0}, MIN_MAX);
    assign nxt_hr  = min_wrap ? hr_nx : hr;
    assign nxt_pm  = pm ^ (min_wrap && pm_tgl);
    assign al_hit  = sec_carry && alarm_on && (nxt_min == al_min) &&
                     (nxt_hr == al_hr) && (nxt_pm == al_pm);

    always_ff @(posedge clk) begin
        if (reset) begin
            al_min <= '0;
            al_hr  <= HR_RST;
            al_pm  <= 1'b0;
            alarm  <= 1'b0;
        end else begin
            if (al_edit && (set_field == FIELD_MIN))
                al_min <= bcd2_inc(al_min, MIN_MAX);
            if (al_edit && (set_field == FIELD_HR)) begin
                al_hr <= hr_next(al_hr, MODE24);
                if (!MODE24 && (al_hr == bcd2_of(11)))
                    al_pm <= ~al_pm;
            end
            if (stop || !alarm_on)
                alarm <= 1'b0;
            else if (al_hit)
                alarm <= 1'b1;
            else if (sec_carry)
                alarm <= 1'b0;
        end
    end
`endif

endmodule
